// File: rtl/tick_scheduler.sv
// Round-robin tick scheduler: one shared period counter hands single-cycle
// tick pulses to the enabled consumer channels in turn.
module tick_scheduler #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int NCH_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [NCH-1:0]      cfg_mask,
    output logic [NCH-1:0]      tick,
    output logic [NCH_BITS-1:0] tick_ch,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RELOAD = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    localparam logic [NCH_BITS-1:0] PTR_INIT = NCH_BITS'(NCH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_period;
    logic [NCH-1:0]        r_mask;
    logic [WIDTH-1:0]      r_count;
    logic [NCH_BITS-1:0]   r_ptr;
    logic [NCH-1:0]        r_tick;
    logic [NCH_BITS-1:0]   r_tick_ch;
    logic                  w_accept;
    logic                  w_expire;
    logic                  w_found;
    logic [NCH_BITS-1:0]   w_cand;
    logic [NCH_BITS-1:0]   w_next_ch;

    assign w_accept = cfg_valid && cfg_ready;
    assign w_expire = (r_count == r_period);
    assign tick     = r_tick;
    assign tick_ch  = r_tick_ch;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_RELOAD;
            S_RELOAD: w_state_next = ((r_period != '0) && (r_mask != '0)) ? S_RUN : S_IDLE;
            S_RUN:    if (w_accept) w_state_next = S_RELOAD;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Outputs decode the state register only, so nothing follows the inputs combinationally.
    always_comb begin
        cfg_ready = (r_state != S_RELOAD);
        busy      = (r_state == S_RUN);
    end

    // Upward search (modulo NCH) for the first enabled channel after the last one served.
    always_comb begin
        w_next_ch = r_ptr;
        w_found   = 1'b0;
        w_cand    = r_ptr;
        for (int i = 1; i <= NCH; i++) begin
            w_cand = NCH_BITS'((int'(r_ptr) + i) % NCH);
            if (!w_found && r_mask[w_cand]) begin
                w_found   = 1'b1;
                w_next_ch = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period  <= '0;
            r_mask    <= '0;
            r_count   <= '0;
            r_ptr     <= PTR_INIT;
            r_tick    <= '0;
            r_tick_ch <= '0;
        end else if (w_accept) begin
            // A new configuration beats a coincident expiry: no tick, pointer restarts.
            r_period <= cfg_period;
            r_mask   <= cfg_mask;
            r_count  <= '0;
            r_ptr    <= PTR_INIT;
            r_tick   <= '0;
        end else if (r_state == S_RUN) begin
            if (w_expire) begin
                r_count   <= '0;
                r_tick    <= {{(NCH-1){1'b0}}, 1'b1} << w_next_ch;
                r_tick_ch <= w_next_ch;
                r_ptr     <= w_next_ch;
            end else begin
                r_count <= r_count + WIDTH'(1);
                r_tick  <= '0;
            end
        end else begin
            r_tick <= '0;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: reset, round-robin order, masking,
// disabled configurations, reconfiguration on expiry and reset priority.
module tb_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [3:0] cfg_mask;
    logic [3:0] tick;
    logic [1:0] tick_ch;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    tick_scheduler #(.WIDTH(8), .NCH(4), .NCH_BITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_period(cfg_period),
        .cfg_mask  (cfg_mask),
        .tick      (tick),
        .tick_ch   (tick_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Offers one configuration for a single edge; returns just after edge E.
    task automatic send_cfg(input logic [7:0] p, input logic [3:0] m);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_mask   = m;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        int nticks = 0;
        int nbusy  = 0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        step();
        step();
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || tick !== 4'b0 || tick_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b busy=%b tick=%b ch=%0d, want 1 0 0000 0",
                     cfg_ready, busy, tick, tick_ch);
        end
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (tick !== 4'b0) nticks++;
            if (busy !== 1'b0) nbusy++;
        end
        n_tests++;
        if (nticks != 0 || nbusy != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d tick cycles %0d busy cycles, want 0 0", nticks, nbusy);
        end
    endtask

    task automatic test_round_robin();
        int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] exp_tick;
        do_reset();
        send_cfg(8'd3, 4'b1111);
        n_tests++;
        if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_reload: got ready=%b busy=%b, want 0 0", cfg_ready, busy);
        end
        step();
        n_tests++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1 || tick !== 4'b0) begin
            n_fail++;
            $display("FAIL rr_run_entry: got busy=%b ready=%b tick=%b, want 1 1 0000", busy, cfg_ready, tick);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_tick = (k % 4 == 0) ? (4'b0001 << exp_ch[k/4 - 1]) : 4'b0000;
            n_tests++;
            if (tick !== exp_tick) begin
                n_fail++;
                $display("FAIL rr_tick cycle %0d: got %b, want %b", k, tick, exp_tick);
            end
            if (k % 4 == 0) begin
                n_tests++;
                if (tick_ch !== 2'(exp_ch[k/4 - 1])) begin
                    n_fail++;
                    $display("FAIL rr_tick_ch cycle %0d: got %0d, want %0d", k, tick_ch, exp_ch[k/4 - 1]);
                end
            end
        end
    endtask

    task automatic test_mask();
        int exp_ch[4] = '{1, 3, 1, 3};
        logic [3:0] exp_tick;
        int bad = 0;
        do_reset();
        send_cfg(8'd2, 4'b1010);
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_tick = (k % 3 == 0) ? (4'b0001 << exp_ch[k/3 - 1]) : 4'b0000;
            n_tests++;
            if (tick !== exp_tick) begin
                n_fail++;
                $display("FAIL mask_tick cycle %0d: got %b, want %b", k, tick, exp_tick);
            end
            if (tick[0] !== 1'b0 || tick[2] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mask_disabled_ch: got %0d cycles ticking ch0/ch2, want 0", bad);
        end
    endtask

    task automatic test_disabled(input logic [7:0] p, input logic [3:0] m);
        int nticks = 0;
        int nbusy  = 0;
        do_reset();
        send_cfg(p, m);
        n_tests++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_reload p=%0d m=%b: got ready=%b, want 0", p, m, cfg_ready);
        end
        step();
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_idle p=%0d m=%b: got ready=%b busy=%b, want 1 0", p, m, cfg_ready, busy);
        end
        for (int k = 0; k < 50; k++) begin
            step();
            if (tick !== 4'b0) nticks++;
            if (busy !== 1'b0) nbusy++;
        end
        n_tests++;
        if (nticks != 0 || nbusy != 0) begin
            n_fail++;
            $display("FAIL dis_quiet p=%0d m=%b: got %0d ticks %0d busy, want 0 0", p, m, nticks, nbusy);
        end
    endtask

    task automatic test_reconfig_on_expiry();
        logic [3:0] exp_tick;
        do_reset();
        send_cfg(8'd3, 4'b1111);
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_tick = (k == 4) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (tick !== exp_tick) begin
                n_fail++;
                $display("FAIL rc_pre cycle %0d: got %b, want %b", k, tick, exp_tick);
            end
        end
        // Count now equals the period: the next edge is both expiry and accept.
        send_cfg(8'd1, 4'b0100);
        n_tests++;
        if (tick !== 4'b0 || cfg_ready !== 1'b0 || tick_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL rc_collide: got tick=%b ready=%b ch=%0d, want 0000 0 0", tick, cfg_ready, tick_ch);
        end
        step();
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_run: got ready=%b busy=%b, want 1 1", cfg_ready, busy);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_tick = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            n_tests++;
            if (tick !== exp_tick || (k % 2 == 0 && tick_ch !== 2'd2)) begin
                n_fail++;
                $display("FAIL rc_post cycle %0d: got tick=%b ch=%0d, want %b ch=2", k, tick, tick_ch, exp_tick);
            end
        end
    endtask

    task automatic test_reset_priority();
        int nticks = 0;
        int nbusy  = 0;
        do_reset();
        send_cfg(8'd3, 4'b1111);
        step();
        for (int k = 1; k <= 8; k++) step();
        n_tests++;
        if (tick !== 4'b0010 || tick_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL rp_setup: got tick=%b ch=%0d, want 0010 1", tick, tick_ch);
        end
        reset      = 1'b1;
        cfg_valid  = 1'b1;
        cfg_period = 8'd1;
        cfg_mask   = 4'b0001;
        step();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        n_tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || tick !== 4'b0 || tick_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL rp_values: got ready=%b busy=%b tick=%b ch=%0d, want 1 0 0000 0",
                     cfg_ready, busy, tick, tick_ch);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick !== 4'b0) nticks++;
            if (busy !== 1'b0) nbusy++;
        end
        n_tests++;
        if (nticks != 0 || nbusy != 0) begin
            n_fail++;
            $display("FAIL rp_not_loaded: got %0d ticks %0d busy, want 0 0", nticks, nbusy);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_mask   = 4'b0;
        test_reset();
        test_round_robin();
        test_mask();
        test_disabled(8'd0, 4'b1111);
        test_disabled(8'd5, 4'b0000);
        test_reconfig_on_expiry();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
